ad_lvds_delay_cal: RTL and testbench

Calibration sequencer for the per-lane LVDS input delay lines on the AD9361 receive interface. On request it loads all 32 delay taps on every lane in turn and samples a per-lane pattern-check status at each tap. It then finds the widest passing window per lane, loads each lane's delay with the window centre and reads it back to confirm the load. It runs in the `up_clk` domain and drives the `up_dld`/`up_dwdata` delay-load ports of the lane receivers.

---
 rtl/ad_lvds_delay_cal_if.sv | 12 +
 rtl/ad_lvds_delay_cal.sv | 157 +++++++++++++++
 tb/tb_ad_lvds_delay_cal.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ad_lvds_delay_cal_if.sv
// Delay-line control bus between the calibration sequencer and the lane receivers.
// up_dld is a one-cycle load strobe that qualifies up_dwdata and has no back-pressure; up_drdata is always valid.
interface ad_lvds_delay_cal_if #(
   parameter int NUM_LANES = 6
);
   logic [NUM_LANES-1:0]   up_dld;
   logic [5*NUM_LANES-1:0] up_dwdata;
   logic [5*NUM_LANES-1:0] up_drdata;

   modport master (output up_dld, output up_dwdata, input up_drdata);
   modport slave  (input up_dld, input up_dwdata, output up_drdata);
endinterface

// File: rtl/ad_lvds_delay_cal.sv
// LVDS input-delay calibration: sweeps all 32 taps on every lane, finds the widest
// passing window per lane, loads its centre and confirms it by readback.
module ad_lvds_delay_cal #(
   parameter int NUM_LANES     = 6,
   parameter int SETTLE_CYCLES = 16,
   parameter int SAMPLE_CYCLES = 64,
   parameter int MIN_WINDOW    = 4
) (
   input  logic                   up_clk,
   input  logic                   up_rstn,
   input  logic                   cal_start,
   input  logic [NUM_LANES-1:0]   lane_ok,
   ad_lvds_delay_cal_if.master    dly,
   output logic                   cal_busy,
   output logic                   cal_done,
   output logic [NUM_LANES-1:0]   cal_error,
   output logic [5*NUM_LANES-1:0] cal_tap,
   output logic [2:0]             dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_APPLY, S_VERIFY, S_DONE
   } state_t;

   state_t                 r_state, w_next;
   logic [4:0]             r_tap;
   logic [7:0]             r_cnt;
   logic [NUM_LANES-1:0]   r_pass;
   logic [5:0]             r_run_len    [NUM_LANES];
   logic [4:0]             r_run_start  [NUM_LANES];
   logic [5:0]             r_best_len   [NUM_LANES];
   logic [4:0]             r_best_start [NUM_LANES];
   logic [5:0]             w_nrun       [NUM_LANES];
   logic [4:0]             w_nstart     [NUM_LANES];
   logic [5*NUM_LANES-1:0] r_dwdata, w_dwdata, w_centre;
   logic [NUM_LANES-1:0]   r_error;
   logic [5*NUM_LANES-1:0] r_cal_tap;

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (cal_start) w_next = S_LOAD;
         S_LOAD:   w_next = S_SETTLE;
         S_SETTLE: if (r_cnt == 8'd0) w_next = S_SAMPLE;
         S_SAMPLE: if (r_cnt == 8'd0) w_next = S_EVAL;
         S_EVAL:   w_next = (r_tap == 5'd31) ? S_APPLY : S_LOAD;
         S_APPLY:  w_next = S_VERIFY;
         S_VERIFY: if (r_cnt == 8'd0) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Window bookkeeping for the tap just sampled, and the resulting per-lane centre.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         w_nrun[i]   = r_pass[i] ? r_run_len[i] + 6'd1 : 6'd0;
         w_nstart[i] = (r_pass[i] && r_run_len[i] == 6'd0) ? r_tap : r_run_start[i];
         w_centre[5*i +: 5] = (r_best_len[i] == 6'd0) ? 5'd0
                              : 5'(r_best_start[i] + 5'(r_best_len[i] >> 1));
      end
   end

   always_comb begin
      w_dwdata = r_dwdata;
      case (r_state)
         S_LOAD:  w_dwdata = {NUM_LANES{r_tap}};
         S_APPLY: w_dwdata = w_centre;
         default: w_dwdata = r_dwdata;
      endcase
   end

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_tap     <= 5'd0;
         r_cnt     <= 8'd0;
         r_pass    <= '0;
         r_dwdata  <= '0;
         r_error   <= '0;
         r_cal_tap <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            r_run_len[i]    <= 6'd0;
            r_run_start[i]  <= 5'd0;
            r_best_len[i]   <= 6'd0;
            r_best_start[i] <= 5'd0;
         end
      end else begin
         r_dwdata <= w_dwdata;
         case (r_state)
            S_IDLE: if (cal_start) begin
               r_tap     <= 5'd0;
               r_error   <= '0;
               r_cal_tap <= '0;
               for (int i = 0; i < NUM_LANES; i++) begin
                  r_run_len[i]    <= 6'd0;
                  r_run_start[i]  <= 5'd0;
                  r_best_len[i]   <= 6'd0;
                  r_best_start[i] <= 5'd0;
               end
            end
            S_LOAD: r_cnt <= 8'(SETTLE_CYCLES - 1);
            S_SETTLE: begin
               if (r_cnt == 8'd0) begin
                  r_cnt  <= 8'(SAMPLE_CYCLES - 1);
                  r_pass <= '1;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_SAMPLE: begin
               r_pass <= r_pass & lane_ok;
               if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
            end
            S_EVAL: begin
               // Strict compare keeps the earliest of equally wide windows.
               for (int i = 0; i < NUM_LANES; i++) begin
                  r_run_len[i]   <= w_nrun[i];
                  r_run_start[i] <= w_nstart[i];
                  if (r_pass[i] && w_nrun[i] > r_best_len[i]) begin
                     r_best_len[i]   <= w_nrun[i];
                     r_best_start[i] <= w_nstart[i];
                  end
               end
               if (r_tap != 5'd31) r_tap <= r_tap + 5'd1;
            end
            S_APPLY: begin
               r_cal_tap <= w_centre;
               r_cnt     <= 8'd1;
            end
            S_VERIFY: begin
               if (r_cnt == 8'd0) begin
                  for (int i = 0; i < NUM_LANES; i++)
                     r_error[i] <= (r_best_len[i] < 6'(MIN_WINDOW)) ||
                                   (dly.up_drdata[5*i +: 5] != w_centre[5*i +: 5]);
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dly.up_dld    = (r_state == S_LOAD || r_state == S_APPLY) ? '1 : '0;
   assign dly.up_dwdata = w_dwdata;
   assign cal_busy      = (r_state != S_IDLE);
   assign cal_done      = (r_state == S_DONE);
   assign cal_error     = r_error;
   assign cal_tap       = r_cal_tap;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_ad_lvds_delay_cal.sv
// Bench for ad_lvds_delay_cal: per-lane tap-dependent lane_ok responder, window model,
// cycle-accurate compare process and directed calibration scenarios.
module tb_ad_lvds_delay_cal;
   localparam int N        = 6;
   localparam int S        = 16;
   localparam int P        = 64;
   localparam int T        = 2 + S + P;
   localparam int DONE_CYC = 32*T + 4;
   localparam int W        = 6*N;

   logic            up_clk = 1'b0;
   logic            up_rstn;
   logic            cal_start;
   logic [N-1:0]    lane_ok;
   logic            cal_busy, cal_done;
   logic [N-1:0]    cal_error;
   logic [5*N-1:0]  cal_tap;
   logic [2:0]      dbg_state;

   ad_lvds_delay_cal_if #(.NUM_LANES(N)) dly ();

   ad_lvds_delay_cal #(.NUM_LANES(N), .SETTLE_CYCLES(S), .SAMPLE_CYCLES(P), .MIN_WINDOW(4)) dut (
      .up_clk    (up_clk),
      .up_rstn   (up_rstn),
      .cal_start (cal_start),
      .lane_ok   (lane_ok),
      .dly       (dly.master),
      .cal_busy  (cal_busy),
      .cal_done  (cal_done),
      .cal_error (cal_error),
      .cal_tap   (cal_tap),
      .dbg_state (dbg_state)
   );

   always #5 up_clk = ~up_clk;

   int             n_cmp = 0;
   int             n_bad = 0;
   logic           track = 1'b0;
   int             cyc = 0;
   logic [31:0]    ok_mask [N];
   logic [N-1:0]   force_rd;
   int             glitch_lane = -1;
   int             glitch_tap  = -1;
   logic [4:0]     loaded [N];
   logic [W-1:0]   exp_q [$];
   logic [W-1:0]   cur_exp = '0;
   logic [5*N-1:0] e_dw = '0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   // Widest run of set bits, earliest on ties.
   function automatic void widest(input logic [31:0] m, output int blen, output int bstart);
      int e;
      logic prev;
      blen = 0; bstart = 0; prev = 1'b0;
      for (int s = 0; s < 32; s++) begin
         if (m[s] && !prev) begin
            e = s;
            while (e < 32 && m[e]) e++;
            if (e - s > blen) begin blen = e - s; bstart = s; end
         end
         prev = m[s];
      end
   endfunction

   function automatic logic [W-1:0] model_expect();
      logic [W-1:0] r;
      logic [31:0] m;
      int l, st, c, rb;
      r = '0;
      for (int i = 0; i < N; i++) begin
         m = ok_mask[i];
         if (glitch_lane == i && glitch_tap >= 0) m[glitch_tap] = 1'b0;
         widest(m, l, st);
         c  = (l == 0) ? 0 : st + l/2;
         rb = force_rd[i] ? 0 : c;
         r[5*i +: 5] = 5'(c);
         r[5*N + i]  = (l < 4) || (rb != c);
      end
      return r;
   endfunction

   // Lane receivers: remember the last loaded tap and answer lane_ok / readback from it.
   initial for (int i = 0; i < N; i++) loaded[i] = 5'd0;
   always @(negedge up_clk) begin
      for (int i = 0; i < N; i++) begin
         if (dly.up_dld[i]) loaded[i] = dly.up_dwdata[5*i +: 5];
         lane_ok[i] = ok_mask[i][loaded[i]];
         if (track && i == glitch_lane && glitch_tap >= 0 && cyc == glitch_tap*T + 2 + S + 30)
            lane_ok[i] = 1'b0;
         dly.up_drdata[5*i +: 5] = force_rd[i] ? 5'd0 : loaded[i];
      end
   end

   always @(posedge up_clk) cyc <= track ? cyc + 1 : 0;

   always @(negedge up_clk) begin
      logic is_load, is_apply;
      logic [5*N-1:0] rep;
      if (track && cyc > 0) begin
         is_load  = (cyc <= 31*T + 1) && ((cyc - 1) % T == 0);
         is_apply = (cyc == 32*T + 1);
         if (is_load) begin
            for (int i = 0; i < N; i++) rep[5*i +: 5] = 5'((cyc - 1) / T);
            e_dw = rep;
         end
         if (is_apply) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL scoreboard_empty: got none required one entry (cyc %0d)", cyc);
            end else begin
               cur_exp = exp_q.pop_front();
            end
            e_dw = cur_exp[5*N-1:0];
         end
         chk("busy", cal_busy, cyc <= DONE_CYC);
         chk("done", cal_done, cyc == DONE_CYC);
         chk("dld", dly.up_dld, (is_load || is_apply) ? {N{1'b1}} : {N{1'b0}});
         chk("dwdata", dly.up_dwdata, e_dw);
         if (cyc >= DONE_CYC) begin
            chk("cal_tap", cal_tap, cur_exp[5*N-1:0]);
            chk("cal_error", cal_error, cur_exp[W-1:5*N]);
         end
      end
   end

   task automatic set_all_ok();
      for (int i = 0; i < N; i++) ok_mask[i] = 32'hFFFF_FFFF;
      force_rd = '0; glitch_lane = -1; glitch_tap = -1;
   endtask

   task automatic run_cal(input logic poke);
      exp_q.push_back(model_expect());
      cal_start = 1'b1;
      track = 1'b1;
      @(posedge up_clk); #1 cal_start = 1'b0;
      for (int k = 0; k < 32*T + 20; k++) begin
         @(negedge up_clk);
         cal_start = poke && cyc >= 500 && cyc < 503;
         if (cyc >= DONE_CYC + 2) break;
      end
      cal_start = 1'b0;
      track = 1'b0;
      chk("queue_drained", exp_q.size(), 0);
      @(negedge up_clk);
      @(negedge up_clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_dld"},    dly.up_dld, 0);
      chk({tag, "_dwdata"}, dly.up_dwdata, 0);
      chk({tag, "_busy"},   cal_busy, 0);
      chk({tag, "_done"},   cal_done, 0);
      chk({tag, "_error"},  cal_error, 0);
      chk({tag, "_tap"},    cal_tap, 0);
      chk({tag, "_state"},  dbg_state, 0);
   endtask

   initial begin
      up_rstn = 1'b0; cal_start = 1'b0; lane_ok = '0;
      set_all_ok();
      repeat (3) @(posedge up_clk);
      @(negedge up_clk);
      check_reset_outputs("por");
      up_rstn = 1'b1;
      repeat (2) @(negedge up_clk);

      // All lanes OK everywhere; extra start requests mid-run must be ignored.
      set_all_ok();
      chk("model_all_ok", model_expect(), {6'b000000, {6{5'd16}}});
      run_cal(1'b1);
      chk("all_ok_tap", cal_tap, {6{5'd16}});
      chk("all_ok_err", cal_error, 6'b000000);

      // Mixed windows, narrow window, dead lane, bad readback.
      ok_mask[0] = 32'h000F_FC00;
      ok_mask[1] = 32'h0FF0_0078;
      ok_mask[2] = 32'h01F0_007C;
      ok_mask[3] = 32'h0000_0700;
      ok_mask[4] = 32'h0000_0000;
      ok_mask[5] = 32'hFFFF_FFFF;
      force_rd   = 6'b100000;
      chk("model_mixed", model_expect(),
          {6'b111000, 5'd16, 5'd0, 5'd9, 5'd4, 5'd24, 5'd15});
      run_cal(1'b0);
      chk("mixed_tap", cal_tap, {5'd16, 5'd0, 5'd9, 5'd4, 5'd24, 5'd15});
      chk("mixed_err", cal_error, 6'b111000);

      // One-cycle lane_ok drop during tap 13 splits lane 0 into 0..12 and 14..31.
      set_all_ok();
      glitch_lane = 0; glitch_tap = 13;
      chk("model_glitch", model_expect(), {6'b000000, {5{5'd16}}, 5'd23});
      run_cal(1'b0);
      chk("glitch_tap", cal_tap, {{5{5'd16}}, 5'd23});

      // Reset during tap 7 settle.
      set_all_ok();
      cal_start = 1'b1;
      track = 1'b1;
      @(posedge up_clk); #1 cal_start = 1'b0;
      for (int k = 0; k < 8*T; k++) begin
         @(negedge up_clk);
         if (cyc == 7*T + 5) break;
      end
      chk("abort_in_settle", dbg_state, 3'd2);
      track = 1'b0;
      up_rstn = 1'b0;
      #1 check_reset_outputs("mid");
      repeat (2) @(negedge up_clk);
      chk("mid_held_busy", cal_busy, 0);
      up_rstn = 1'b1;
      repeat (2) @(negedge up_clk);
      check_reset_outputs("post");

      // Fresh start after the abort.
      ok_mask[0] = 32'h000F_FC00;
      ok_mask[1] = 32'h0FF0_0078;
      run_cal(1'b0);
      chk("fresh_tap", cal_tap, {{4{5'd16}}, 5'd24, 5'd15});
      chk("fresh_err", cal_error, 6'b000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
